int_ctrl: RTL

Interrupt controller directly downstream of the machine timer. It collects the timer's level interrupt, a memory-mapped software interrupt and `NUM_EXT` external lines. It masks and prioritises them and presents one interrupt request with a source ID to the core. A claim/complete handshake on its register window prevents re-entry while a handler runs.

---
 rtl/int_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: software, timer and NUM_EXT external sources, fixed priority,
// claim/complete handshake. Define INTC_EDGE_EN for edge-triggered external sources.
module int_ctrl #(
   parameter int unsigned NUM_EXT = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                int_timer_i,
   input  logic [NUM_EXT-1:0]  int_ext_i,
   input  logic                intc_wr_en_i,
   input  logic [19:0]         intc_wr_addr_i,
   input  logic [31:0]         intc_wr_data_i,
   input  logic                intc_rd_en_i,
   input  logic [19:0]         intc_rd_addr_i,
   output logic [31:0]         intc_rd_data_o,
   output logic                irq_o,
   output logic [4:0]          irq_id_o,
   input  logic                irq_ack_i
);

   localparam int unsigned NSRC    = NUM_EXT + 3;
   localparam logic [19:0] A_PEND  = 20'h0_0000;
   localparam logic [19:0] A_EN    = 20'h0_0004;
   localparam logic [19:0] A_MSIP  = 20'h0_0008;
   localparam logic [19:0] A_CLAIM = 20'h0_000C;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_CLAIMED} state_t;

   state_t              r_state, w_next;
   logic [4:0]          r_id, w_best;
   logic                r_msip, r_timer;
   logic [NUM_EXT-1:0]  r_ext_pend;
   logic [NSRC-1:1]     r_en;
   logic [31:0]         w_pend32, w_en32, w_active;
   logic                w_any, w_wr_en, w_wr_msip, w_claim_ok, w_unused;

   assign w_wr_en    = intc_wr_en_i && (intc_wr_addr_i == A_EN);
   assign w_wr_msip  = intc_wr_en_i && (intc_wr_addr_i == A_MSIP);
   assign w_claim_ok = intc_wr_en_i && (intc_wr_addr_i == A_CLAIM) &&
                       (r_state == S_CLAIMED) && (intc_wr_data_i[4:0] == r_id);
   assign w_unused   = &{1'b0, intc_wr_data_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_en    <= '0;
         r_msip  <= 1'b0;
         r_timer <= 1'b0;
      end else begin
         if (w_wr_en)   r_en   <= intc_wr_data_i[NSRC-1:1];
         if (w_wr_msip) r_msip <= intc_wr_data_i[0];
         r_timer <= int_timer_i;
      end
   end

`ifdef INTC_EDGE_EN
   logic [NUM_EXT-1:0] r_ext_d;

   // A new rising edge outranks an ack-clear landing in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ext_d    <= '0;
         r_ext_pend <= '0;
      end else begin
         r_ext_d <= int_ext_i;
         for (int unsigned k = 0; k < NUM_EXT; k++) begin
            if (int_ext_i[k] && !r_ext_d[k])
               r_ext_pend[k] <= 1'b1;
            else if (irq_ack_i && (r_state == S_REQ) && (r_id == 5'(k + 3)))
               r_ext_pend[k] <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge clk_i) begin
      if (rst_i) r_ext_pend <= '0;
      else       r_ext_pend <= int_ext_i;
   end
`endif

   always_comb begin
      w_pend32             = '0;
      w_pend32[1]          = r_msip;
      w_pend32[2]          = r_timer;
      w_pend32[NSRC-1:3]   = r_ext_pend;
      w_en32               = '0;
      w_en32[NSRC-1:1]     = r_en;
      w_active             = w_pend32 & w_en32;
      w_any                = |w_active;
   end

   // Scan downward so the lowest active ID is the one left standing.
   always_comb begin
      w_best = '0;
      for (int unsigned i = NSRC - 1; i >= 1; i--) begin
         if (w_active[i]) w_best = 5'(i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_id    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_any) r_id <= w_best;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_any) w_next = S_REQ;
         S_REQ: begin
            if (irq_ack_i)              w_next = S_CLAIMED;
            else if (!w_active[r_id])   w_next = S_IDLE;
         end
         S_CLAIMED: if (w_claim_ok) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      irq_o    = 1'b0;
      irq_id_o = '0;
      if (r_state == S_REQ) begin
         irq_o    = 1'b1;
         irq_id_o = r_id;
      end
   end

   always_comb begin
      intc_rd_data_o = '0;
      if (intc_rd_en_i) begin
         case (intc_rd_addr_i)
            A_PEND:  intc_rd_data_o = w_pend32;
            A_EN:    intc_rd_data_o = w_en32;
            A_MSIP:  intc_rd_data_o = {31'b0, r_msip};
            A_CLAIM: intc_rd_data_o = (r_state == S_CLAIMED) ? {27'b0, r_id} : '0;
            default: intc_rd_data_o = '0;
         endcase
      end
   end

endmodule
